// File: rtl/prio_arbiter.sv
// Registered N-way priority arbiter with fixed-priority and round-robin policies.
// Each grant is held (valid/ready) until the consumer accepts it.
`timescale 1ns/1ps
module prio_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_oh
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam logic [N-1:0] ONE_OH   = {{(N-1){1'b0}}, 1'b1};

    state_t         state_r;
    logic [W-1:0]   ptr_r;
    logic [W-1:0]   ptr_next_s;
    logic [W-1:0]   base_s;
    logic           accept_s;
    logic           win_found_s;
    logic [W-1:0]   win_idx_s;
    logic [N-1:0]   win_oh_s;

    // Descending search with wrap from 'start': the highest set bit at or below
    // 'start' wins; failing that, the highest set bit above it. Returns {found, idx}.
    function automatic logic [W:0] pick_winner(input logic [N-1:0] r,
                                               input logic [W-1:0] start);
        logic         lo_found;
        logic         any_found;
        logic [W-1:0] lo_idx;
        logic [W-1:0] any_idx;
        lo_found  = 1'b0;
        any_found = 1'b0;
        lo_idx    = {W{1'b0}};
        any_idx   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (|(r & (ONE_OH << i))) begin
                any_found = 1'b1;
                any_idx   = W'(i);
                if (W'(i) <= start) begin
                    lo_found = 1'b1;
                    lo_idx   = W'(i);
                end else begin
                    lo_found = lo_found;
                end
            end else begin
                any_found = any_found;
            end
        end
        if (lo_found) begin
            return {1'b1, lo_idx};
        end else begin
            return {any_found, any_idx};
        end
    endfunction

    // Next pointer and winner; fixed priority is a search that always starts at N-1.
    always_comb begin
        accept_s   = (state_r == ST_GRANT) && gnt_ready;
        ptr_next_s = ptr_r;
        if (accept_s && mode) begin
            if (gnt_idx == {W{1'b0}}) begin
                ptr_next_s = LAST_IDX;
            end else begin
                ptr_next_s = gnt_idx - W'(1);
            end
        end else begin
            ptr_next_s = ptr_r;
        end
        if (mode) begin
            base_s = ptr_next_s;
        end else begin
            base_s = LAST_IDX;
        end
        {win_found_s, win_idx_s} = pick_winner(req, base_s);
        win_oh_s = ONE_OH << win_idx_s;
    end

    // Grant state machine with registered outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= LAST_IDX;
            gnt_valid <= 1'b0;
            gnt_idx   <= {W{1'b0}};
            gnt_oh    <= {N{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r   <= ST_GRANT;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= win_idx_s;
                        gnt_oh    <= win_oh_s;
                    end
                end
                ST_GRANT: begin
                    // Grant is sticky until accepted; a new winner follows with no bubble.
                    if (gnt_ready) begin
                        ptr_r <= ptr_next_s;
                        if (win_found_s) begin
                            gnt_idx <= win_idx_s;
                            gnt_oh  <= win_oh_s;
                        end else begin
                            state_r   <= ST_IDLE;
                            gnt_valid <= 1'b0;
                            gnt_idx   <= {W{1'b0}};
                            gnt_oh    <= {N{1'b0}};
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gnt_valid <= 1'b0;
                    gnt_idx   <= {W{1'b0}};
                    gnt_oh    <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=8): directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_prio_arbiter;

    localparam int NUM = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NUM-1:0] req = 8'h00;
    logic           mode = 1'b0;
    logic           gnt_ready = 1'b0;
    logic           gnt_valid;
    logic [2:0]     gnt_idx;
    logic [NUM-1:0] gnt_oh;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    prio_arbiter #(.N(NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_oh    (gnt_oh)
    );

    always #5 clk = ~clk;

    function automatic int model_winner(input logic [NUM-1:0] r, input logic md, input int p);
        if (!md) begin
            for (int i = NUM - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 0; k < NUM; k++) begin
                int c;
                c = (p - k + NUM) % NUM;
                if (r[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = NUM - 1;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then settle.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (!m_valid) begin
                if (req != 8'h00) begin
                    m_valid = 1'b1;
                    m_idx   = model_winner(req, mode, m_ptr);
                end
            end else if (gnt_ready) begin
                if (mode) m_ptr = (m_idx + NUM - 1) % NUM;
                if (req != 8'h00) m_idx = model_winner(req, mode, m_ptr);
                else m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; mode = 1'b1; gnt_ready = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_oh !== 8'h00) begin
                n_fails++;
                $display("FAIL reset_hold cyc %0d: got v=%b idx=%0d oh=%h, want v=0 idx=0 oh=00",
                         i, gnt_valid, gnt_idx, gnt_oh);
            end
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7 || gnt_oh !== 8'h80) begin
            n_fails++;
            $display("FAIL reset_release: got v=%b idx=%0d oh=%h, want v=1 idx=7 oh=80",
                     gnt_valid, gnt_idx, gnt_oh);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; req = 8'b0010_0110; gnt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || gnt_oh !== 8'h20) begin
                n_fails++;
                $display("FAIL fixed_prio cyc %0d: got v=%b idx=%0d oh=%h, want v=1 idx=5 oh=20",
                         i, gnt_valid, gnt_idx, gnt_oh);
            end
        end
        req = 8'b0000_0110;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || gnt_oh !== 8'h04) begin
            n_fails++;
            $display("FAIL fixed_drop: got v=%b idx=%0d oh=%h, want v=1 idx=2 oh=04",
                     gnt_valid, gnt_idx, gnt_oh);
        end
    endtask

    task automatic test_rr_sweep();
        mode = 1'b0; req = 8'h00; gnt_ready = 1'b1;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0 || gnt_oh !== 8'h00) begin
            n_fails++;
            $display("FAIL rr_drain: got v=%b oh=%h, want v=0 oh=00", gnt_valid, gnt_oh);
        end
        mode = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] one;
            int         exp_idx;
            one = 8'h01;
            exp_idx = (15 - i) % NUM;
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_idx) || gnt_oh !== (one << exp_idx)) begin
                n_fails++;
                $display("FAIL rr_sweep cyc %0d: got v=%b idx=%0d oh=%h, want v=1 idx=%0d",
                         i, gnt_valid, gnt_idx, gnt_oh, exp_idx);
            end
        end
    endtask

    task automatic test_sticky();
        req = 8'h00; gnt_ready = 1'b1; mode = 1'b1;
        step();
        n_checks++;
        if (gnt_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL sticky_drain: got v=%b, want v=0", gnt_valid);
        end
        req = 8'b0000_1001; gnt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) req = 8'h00;
            if (i == 2) mode = 1'b0;
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || gnt_oh !== 8'h08) begin
                n_fails++;
                $display("FAIL sticky_hold cyc %0d: got v=%b idx=%0d oh=%h, want v=1 idx=3 oh=08",
                         i, gnt_valid, gnt_idx, gnt_oh);
            end
        end
        mode = 1'b1; gnt_ready = 1'b1;
        step();
        gnt_ready = 1'b0;
        n_checks++;
        if (gnt_valid !== 1'b0 || gnt_oh !== 8'h00) begin
            n_fails++;
            $display("FAIL sticky_accept: got v=%b oh=%h, want v=0 oh=00", gnt_valid, gnt_oh);
        end
    endtask

    task automatic test_ptr_wrap();
        int exp_seq[3] = '{0, 5, 4};
        req = 8'h10; mode = 1'b1; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4) begin
            n_fails++;
            $display("FAIL wrap_setup: got v=%b idx=%0d, want v=1 idx=4", gnt_valid, gnt_idx);
        end
        gnt_ready = 1'b1; req = 8'b0011_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_seq[i])) begin
                n_fails++;
                $display("FAIL ptr_wrap step %0d: got v=%b idx=%0d, want v=1 idx=%0d",
                         i, gnt_valid, gnt_idx, exp_seq[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 8'h00; gnt_ready = 1'b1;
        step();
        mode = 1'b0; req = 8'h40; gnt_ready = 1'b0;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6 || gnt_oh !== 8'h40) begin
            n_fails++;
            $display("FAIL async_setup: got v=%b idx=%0d oh=%h, want v=1 idx=6 oh=40",
                     gnt_valid, gnt_idx, gnt_oh);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_oh !== 8'h00) begin
            n_fails++;
            $display("FAIL async_reset: got v=%b idx=%0d oh=%h, want v=0 idx=0 oh=00",
                     gnt_valid, gnt_idx, gnt_oh);
        end
        model_reset();
        req = 8'h01;
        #2 rst_n = 1'b1;
        step();
        n_checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_oh !== 8'h01) begin
            n_fails++;
            $display("FAIL async_release: got v=%b idx=%0d oh=%h, want v=1 idx=0 oh=01",
                     gnt_valid, gnt_idx, gnt_oh);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] one;
            logic [7:0] exp_oh;
            if ($urandom_range(0, 3) == 0) req = 8'h00;
            else req = 8'($urandom);
            mode      = 1'($urandom);
            gnt_ready = ($urandom_range(0, 2) != 0);
            step();
            one    = 8'h01;
            exp_oh = m_valid ? (one << m_idx) : 8'h00;
            n_checks++;
            if (gnt_valid !== m_valid || gnt_oh !== exp_oh ||
                (m_valid && gnt_idx !== 3'(m_idx))) begin
                n_fails++;
                $display("FAIL random cyc %0d: got v=%b idx=%0d oh=%h, want v=%b idx=%0d oh=%h",
                         i, gnt_valid, gnt_idx, gnt_oh, m_valid, m_idx, exp_oh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_sticky();
        test_ptr_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered priority arbiter. It generalises the team's 8-to-3 priority encoder to N requesters and adds two things: a round-robin mode and a valid/ready grant handshake that holds each grant until the consumer accepts it. It sits between N request sources and one shared resource. It produces a registered grant index and a one-hot grant.

## Interface
- N, default 8: number of requesters; legal range 2..32.
- W, default $clog2(N): width of the grant index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request vector; bit i set means requester i is requesting.
- mode  input  1  arbitration policy. 0 = fixed priority, highest index wins. 1 = round-robin.
- gnt_ready  input  1  consumer accepts the current grant when high in a cycle where gnt_valid is high.
- gnt_valid  output  1  a grant is being presented.
- gnt_idx  output  W  index of the granted requester.
- gnt_oh  output  N  one-hot grant; equals 1<<gnt_idx when gnt_valid, else all zero.

## Operation
- The state machine has two states.
  - IDLE: gnt_valid=0.
  - GRANT: gnt_valid=1; gnt_idx and gnt_oh are stable.
- IDLE → GRANT: at any rising edge where req != 0. The winner is computed from req and mode sampled at that edge.
- GRANT, gnt_ready=0: hold. gnt_idx and gnt_oh are unchanged even if req changes or drops to 0 (grants are sticky). A mode change has no effect on the held grant.
- GRANT, gnt_ready=1 (accept):
  - Update the round-robin pointer.
  - If req != 0 at that edge, re-arbitrate and stay in GRANT with the new winner (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Fixed priority (mode=0): the winner is the highest set bit of req.
- Round-robin (mode=1): the search starts at pointer ptr and descends with wrap: ptr, ptr-1, …, 0, N-1, …, ptr+1. The first set bit wins.
- Pointer (W bits):
  - Reset value is N-1, so round-robin initially matches fixed priority.
  - On each accept with mode=1 of index k: ptr ← k-1, or N-1 when k=0.
  - Accepts with mode=0 leave ptr unchanged. ptr is retained across mode switches.
- The winner is only ever taken from set req bits. When req=0 there is no winner and no grant is issued.
- The winner is also only ever taken from indices below N. For non-power-of-2 N, ptr never exceeds N-1.

## Timing
- Reset (rst_n low, asynchronous): gnt_valid=0, gnt_idx=0, gnt_oh=0, ptr=N-1, state IDLE. This takes effect immediately, with no clock needed.
- Reset deasserted: first arbitration happens at the first rising edge with rst_n high.
- Reset mid-grant discards the pending grant. It is not re-presented after reset unless req is still set.
- Latency: req set before edge t → gnt_valid/gnt_idx/gnt_oh valid after edge t (1 cycle, registered outputs).
- Accept: the handshake completes at the edge where gnt_valid && gnt_ready. The next grant (if any) is visible after that same edge.
- Sustained throughput: 1 grant per cycle when gnt_ready is held high and req != 0.
- Simultaneous events:
  - req changing at an accept edge: the new req value is the one arbitrated.
  - gnt_ready high in IDLE: ignored.
- Outputs have no combinational path from req, mode or gnt_ready.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF, mode=1, gnt_ready=1 for 3 cycles → gnt_valid=0, gnt_idx=0, gnt_oh=8'h00 throughout. Release → gnt_idx=7, gnt_oh=8'h80 one edge later.
- Fixed priority: mode=0, req=8'b0010_0110, gnt_ready=1 held → gnt_idx=5 every cycle, gnt_oh=8'h20. Drop bit 5 → next grant is gnt_idx=2.
- Round-robin sweep: mode=1, req=8'hFF, gnt_ready=1 → gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles; gnt_valid never drops.
- Sticky hold: mode=1, req=8'b0000_1001, gnt_ready=0 → gnt_idx=3. Hold 3 cycles, set req=0 → gnt_valid=1, gnt_idx=3 is maintained. Pulse gnt_ready=1 → gnt_valid=0 next cycle.
- Pointer/wrap: in round-robin, accept gnt_idx=4 (ptr becomes 3), then req=8'b0011_0001 → gnt_idx=0. Accept it (ptr becomes 7) → gnt_idx=5, then 4.
- Async reset mid-grant: in GRANT with gnt_idx=6 and gnt_ready=0, pulse rst_n low between edges → outputs go to 0 immediately, without waiting for a clock edge. After release with req=8'h01 → gnt_idx=0, gnt_oh=8'h01.
